hilo_unit: RTL and testbench
============================

# hilo_unit

Parametrised HI/LO unit for the 5-stage pipeline EX stage. It replaces the plain ALU/HI/LO result selector with one that owns the HI and LO registers and runs an iterative unsigned divider (optionally a multiplier). It drives a combinational result mux and a stall back to the hazard unit while a long operation is in flight.

## Interface
- WIDTH, 32: datapath width of operands, HI, LO and result.
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  EX stage holds a valid instruction for this unit.
- op  in  3  operation: 000 DIVU, 001 MFLO, 010 MFHI, 011 ALU pass, 100 MULTU (MULTU only with macro).
- op_a  in  WIDTH  dividend / multiplicand.
- op_b  in  WIDTH  divisor / multiplier.
- alu_in  in  WIDTH  ALU result passed through for non-HI/LO ops.
- flush  in  1  pipeline flush; aborts an in-flight operation.
- result  out  WIDTH  selected EX result.
- stall  out  1  hold IF/ID/EX this cycle.
- busy  out  1  iterative operation in progress.
- div_by_zero  out  1  one-cycle pulse on DIVU with op_b == 0.

One clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- Reset: HI = 0, LO = 0, FSM = IDLE, counter = 0. Outputs: busy 0, stall 0, div_by_zero 0. result is the mux output: alu_in for ALU/DIVU/MULTU, 0 for MFHI/MFLO.
- result (combinational): MFHI -> HI, MFLO -> LO, all other ops -> alu_in.
- FSM states: IDLE, DIV, MUL (MUL exists only with macro).
- IDLE -> DIV: op_valid & op == DIVU & op_b != 0 & !flush. Latch op_a and op_b, and load counter = WIDTH.
- DIVU with op_b == 0 completes in one edge with no busy: HI <= op_a, LO <= all ones, div_by_zero pulses in the following cycle.
- DIV: one restoring-division step per edge; counter decrements. On the edge where the counter reaches 0: LO <= quotient, HI <= remainder, FSM -> IDLE.
- flush in DIV/MUL: FSM -> IDLE on that edge. HI and LO keep their pre-operation values.
- flush together with a start condition: flush wins, nothing starts.
- stall = busy & op_valid & op in {DIVU, MFHI, MFLO, MULTU}. ALU pass never stalls.
- A new DIVU/MULTU is only accepted from IDLE.
- Counter width: $clog2(WIDTH)+1. Partial remainder: WIDTH+1 bits.

## Timing
- Start sampled at edge k. busy is high in the cycles after edges k .. k+W-1, which is exactly WIDTH cycles.
- HI/LO are written at edge k+W, and busy falls at the same edge.
- An MFHI/MFLO in cycle k+W+1 reads the new value, with no bypass from the final iteration.
- An MFHI/MFLO issued while busy stalls until busy falls and completes in the first non-busy cycle.
- Divide-by-zero and IDLE-path latency is 1 edge.
- Flush abort takes effect at the flush edge. busy is 0 in the following cycle.
- Reset asserted mid-operation clears state immediately, with no partial HI/LO write.

## Configuration
- HILO_MULTU_EN defined: op 100 starts an iterative shift-add unsigned multiply. It takes WIDTH cycles, with the same busy, stall and flush rules as DIV, and writes {HI,LO} <= op_a * op_b (2*WIDTH bits) at completion.
- HILO_MULTU_EN undefined: op 100 is treated as ALU pass. There is no busy, no stall, HI/LO are unchanged, and the MUL state and multiplier datapath are absent.

## Structure
- hilo_pkg: op encodings (OP_DIVU, OP_MFLO, OP_MFHI, OP_ALU, OP_MULTU) and the FSM state enum.
- Sub-module hilo_div_core: the iterative datapath (remainder/quotient shift registers, counter, done pulse), shared by DIV and MUL.
- hilo_unit top level: FSM control, HI/LO registers, stall logic and the result mux.

## Test plan
- Reset, then MFHI and MFLO -> result 0x00000000 for both, stall 0, busy 0.
- DIVU 100/7, then MFLO the next cycle -> stall high exactly 32 cycles, then LO = 14. A following MFHI returns HI = 2.
- DIVU 0x1234/0 -> busy never high, div_by_zero pulses 1 cycle, HI = 0x1234, LO = 0xFFFFFFFF.
- HI=2, LO=14 held, start DIVU 0xFFFFFFFF/3, flush on the 10th busy cycle -> busy 0 the next cycle, HI/LO remain 2/14, and a new DIVU is accepted right after.
- ALU pass with alu_in = 0xDEADBEEF while busy -> result 0xDEADBEEF, stall 0.
- MULTU 0xFFFFFFFF*2:
  - With HILO_MULTU_EN: after 32 busy cycles, HI = 0x00000001 and LO = 0xFFFFFFFE.
  - Without the macro: busy stays 0 and HI/LO are unchanged.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared op encodings and FSM state type for the HI/LO unit.
// HILO_MULTU_EN adds the MUL state.
package hilo_pkg;

  localparam logic [2:0] OP_DIVU  = 3'b000;
  localparam logic [2:0] OP_MFLO  = 3'b001;
  localparam logic [2:0] OP_MFHI  = 3'b010;
  localparam logic [2:0] OP_ALU   = 3'b011;
  localparam logic [2:0] OP_MULTU = 3'b100;

`ifdef HILO_MULTU_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_MUL  = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1
  } state_e;
`endif

endpackage

// File: rtl/hilo_div_core.sv
// Iterative restoring divider (and shift-add multiplier with HILO_MULTU_EN).
// hi_nxt/lo_nxt carry the values this step produces, so the caller can commit on done.
module hilo_div_core
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             clear,
`ifdef HILO_MULTU_EN
  input  logic             mul_mode,
`endif
  input  logic [WIDTH-1:0] ld_quot,
  input  logic [WIDTH-1:0] ld_opnd,
  output logic             done,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_step, quot_step;
`ifdef HILO_MULTU_EN
  logic             mode_q, mode_d;
  logic [WIDTH:0]   sum;
`endif

  always_comb begin
    shifted = {rem_q, quot_q[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_q};
    // A clear sign bit means the divisor fits into the shifted remainder.
    if (!diff[WIDTH]) begin
      rem_step  = diff[WIDTH-1:0];
      quot_step = {quot_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step  = shifted[WIDTH-1:0];
      quot_step = {quot_q[WIDTH-2:0], 1'b0};
    end
`ifdef HILO_MULTU_EN
    sum = {1'b0, rem_q} + (quot_q[0] ? {1'b0, opnd_q} : '0);
    if (mode_q) begin
      rem_step  = sum[WIDTH:1];
      quot_step = {sum[0], quot_q[WIDTH-1:1]};
    end
`endif
  end

  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quot_d = quot_q;
    opnd_d = opnd_q;
`ifdef HILO_MULTU_EN
    mode_d = mode_q;
`endif
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d  = CW'(WIDTH);
      rem_d  = '0;
      quot_d = ld_quot;
      opnd_d = ld_opnd;
`ifdef HILO_MULTU_EN
      mode_d = mul_mode;
`endif
    end else if (step) begin
      cnt_d  = cnt_q - CW'(1);
      rem_d  = rem_step;
      quot_d = quot_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      opnd_q <= '0;
`ifdef HILO_MULTU_EN
      mode_q <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quot_q <= quot_d;
      opnd_q <= opnd_d;
`ifdef HILO_MULTU_EN
      mode_q <= mode_d;
`endif
    end
  end

  assign done   = step && (cnt_q == CW'(1));
  assign hi_nxt = rem_step;
  assign lo_nxt = quot_step;

endmodule

// File: rtl/hilo_unit.sv
// EX-stage HI/LO unit: owns HI/LO, sequences DIVU (and MULTU with HILO_MULTU_EN).
// state   | meaning
// ST_IDLE | no long op; DIVU/MULTU accepted here only
// ST_DIV  | restoring division stepping, busy high
// ST_MUL  | shift-add multiply stepping (HILO_MULTU_EN only)
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] alu_in,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic             stall,
  output logic             busy,
  output logic             div_by_zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             dbz_q, dbz_d;
  logic             core_load, core_step, core_clear, core_done;
  logic [WIDTH-1:0] ld_quot, ld_opnd, core_hi, core_lo;
  logic             hilo_op;
`ifdef HILO_MULTU_EN
  logic             mul_mode;
`endif

  hilo_div_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (core_load),
    .step     (core_step),
    .clear    (core_clear),
`ifdef HILO_MULTU_EN
    .mul_mode (mul_mode),
`endif
    .ld_quot  (ld_quot),
    .ld_opnd  (ld_opnd),
    .done     (core_done),
    .hi_nxt   (core_hi),
    .lo_nxt   (core_lo)
  );

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dbz_d      = 1'b0;
    core_load  = 1'b0;
    core_step  = 1'b0;
    core_clear = 1'b0;
    ld_quot    = op_a;
    ld_opnd    = op_b;
`ifdef HILO_MULTU_EN
    mul_mode   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (op_valid && !flush) begin
          if (op == OP_DIVU) begin
            if (op_b != '0) begin
              state_d   = ST_DIV;
              core_load = 1'b1;
            end else begin
              hi_d  = op_a;
              lo_d  = '1;
              dbz_d = 1'b1;
            end
          end
`ifdef HILO_MULTU_EN
          else if (op == OP_MULTU) begin
            state_d   = ST_MUL;
            core_load = 1'b1;
            mul_mode  = 1'b1;
            ld_quot   = op_b;
            ld_opnd   = op_a;
          end
`endif
        end
      end
      default: begin
        // Abort leaves HI/LO untouched; only a completed op commits.
        if (flush) begin
          state_d    = ST_IDLE;
          core_clear = 1'b1;
        end else begin
          core_step = 1'b1;
          if (core_done) begin
            state_d = ST_IDLE;
            hi_d    = core_hi;
            lo_d    = core_lo;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    hilo_op = (op == OP_DIVU) || (op == OP_MFHI) || (op == OP_MFLO);
`ifdef HILO_MULTU_EN
    hilo_op = hilo_op || (op == OP_MULTU);
`endif
  end

  always_comb begin
    result = alu_in;
    case (op)
      OP_MFHI: result = hi_q;
      OP_MFLO: result = lo_q;
      default: result = alu_in;
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign stall       = busy && op_valid && hilo_op;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: vector table, directed multi-cycle sequences,
// and random traffic against a cycle-count/arithmetic reference model.
module tb_hilo_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         op_valid;
  logic [2:0]   op;
  logic [W-1:0] op_a, op_b, alu_in;
  logic         flush;
  logic [W-1:0] result;
  logic         stall, busy, div_by_zero;

  int total = 0;
  int bad   = 0;

  hilo_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid    (op_valid),
    .op          (op),
    .op_a        (op_a),
    .op_b        (op_b),
    .alu_in      (alu_in),
    .flush       (flush),
    .result      (result),
    .stall       (stall),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] alu;
    logic         fl;
    logic [W-1:0] exp_res;
    logic         exp_stall;
    logic         exp_busy;
    logic         exp_dbz;
  } vec_t;

  vec_t vecs[12];

  // reference model state
  int           m_left;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic         m_dbz;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [2:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] alu, input logic f);
    op_valid = v;
    op       = o;
    op_a     = a;
    op_b     = b;
    alu_in   = alu;
    flush    = f;
  endtask

  task automatic do_reset();
    drv(1'b0, 3'b011, '0, '0, '0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Counts busy cycles (starting with the current one) until busy drops.
  task automatic wait_idle(output int n);
    bit fin;
    n   = 0;
    fin = 1'b0;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clk);
      if (busy) begin
        n++;
        @(posedge clk);
        #1;
      end else begin
        fin = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    m_left = 0;
    m_hi   = '0;
    m_lo   = '0;
    p_hi   = '0;
    p_lo   = '0;
    m_dbz  = 1'b0;
  endtask

  task automatic model_check();
    logic         e_busy, e_stall, is_hilo;
    logic [W-1:0] e_res;
    e_busy  = (m_left > 0);
    is_hilo = (op == 3'b000) || (op == 3'b001) || (op == 3'b010);
`ifdef HILO_MULTU_EN
    is_hilo = is_hilo || (op == 3'b100);
`endif
    e_stall = e_busy && op_valid && is_hilo;
    e_res   = (op == 3'b010) ? m_hi : (op == 3'b001) ? m_lo : alu_in;
    chk("rnd_result", result, e_res);
    chk("rnd_stall", stall, e_stall);
    chk("rnd_busy", busy, e_busy);
    chk("rnd_dbz", div_by_zero, m_dbz);
  endtask

  task automatic model_step();
    logic [63:0] prod;
    logic        dbz_n;
    dbz_n = 1'b0;
    if (m_left > 0) begin
      if (flush) begin
        m_left = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
      end
    end else if (op_valid && !flush) begin
      if (op == 3'b000) begin
        if (op_b == 0) begin
          m_hi  = op_a;
          m_lo  = '1;
          dbz_n = 1'b1;
        end else begin
          p_lo   = op_a / op_b;
          p_hi   = op_a % op_b;
          m_left = W;
        end
      end
`ifdef HILO_MULTU_EN
      else if (op == 3'b100) begin
        prod   = {32'b0, op_a} * {32'b0, op_b};
        p_hi   = prod[63:32];
        p_lo   = prod[31:0];
        m_left = W;
      end
`endif
    end
    prod  = '0;
    m_dbz = dbz_n;
  endtask

  initial begin
    int           n;
    bit           fin;
    logic [W-1:0] mul_hi, mul_lo, mfhi_after_mul;
    int           mul_cycles;
    logic         mul_stall;
    logic [W-1:0] rb;

`ifdef HILO_MULTU_EN
    mul_cycles     = 32;
    mul_hi         = 32'h0000_0001;
    mul_lo         = 32'hFFFF_FFFE;
    mul_stall      = 1'b1;
`else
    mul_cycles     = 0;
    mul_hi         = 32'h0000_0003;
    mul_lo         = 32'h0000_000A;
    mul_stall      = 1'b0;
`endif
    mfhi_after_mul = 32'h0000_1234;

    //           v     op      a             b      alu           fl    exp_res       st         busy       dbz
    vecs[0]  = '{1'b1, 3'b010, 32'h0,        32'h0, 32'hAAAA0000, 1'b0, 32'h0,        1'b0,      1'b0,      1'b0};
    vecs[1]  = '{1'b1, 3'b001, 32'h0,        32'h0, 32'h00001111, 1'b0, 32'h0,        1'b0,      1'b0,      1'b0};
    vecs[2]  = '{1'b1, 3'b011, 32'h0,        32'h0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0,      1'b0,      1'b0};
    vecs[3]  = '{1'b1, 3'b000, 32'h1234,     32'h0, 32'h00000033, 1'b0, 32'h00000033, 1'b0,      1'b0,      1'b0};
    vecs[4]  = '{1'b1, 3'b010, 32'h0,        32'h0, 32'h0,        1'b0, 32'h00001234, 1'b0,      1'b0,      1'b1};
    vecs[5]  = '{1'b1, 3'b001, 32'h0,        32'h0, 32'h0,        1'b0, 32'hFFFFFFFF, 1'b0,      1'b0,      1'b0};
    vecs[6]  = '{1'b0, 3'b010, 32'h0,        32'h0, 32'h0,        1'b0, 32'h00001234, 1'b0,      1'b0,      1'b0};
    vecs[7]  = '{1'b1, 3'b000, 32'h5,        32'h0, 32'h00000044, 1'b1, 32'h00000044, 1'b0,      1'b0,      1'b0};
    vecs[8]  = '{1'b1, 3'b010, 32'h0,        32'h0, 32'h0,        1'b0, 32'h00001234, 1'b0,      1'b0,      1'b0};
    vecs[9]  = '{1'b1, 3'b101, 32'h0,        32'h0, 32'h00000055, 1'b0, 32'h00000055, 1'b0,      1'b0,      1'b0};
    vecs[10] = '{1'b1, 3'b100, 32'hFFFFFFFF, 32'h2, 32'h00000077, 1'b0, 32'h00000077, 1'b0,      1'b0,      1'b0};
    vecs[11] = '{1'b1, 3'b010, 32'h0,        32'h0, 32'h0,        1'b0, mfhi_after_mul, mul_stall, mul_stall, 1'b0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      drv(vecs[i].v, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].alu, vecs[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
      chk($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      chk($sformatf("vec%0d_dbz", i), div_by_zero, vecs[i].exp_dbz);
      @(posedge clk);
      #1;
    end

    // DIVU 100/7 followed by a stalled MFLO
    do_reset();
    drv(1'b1, 3'b000, 32'd100, 32'd7, 32'h0, 1'b0);
    @(negedge clk);
    chk("div_start_busy", busy, 1'b0);
    chk("div_start_stall", stall, 1'b0);
    @(posedge clk);
    #1 drv(1'b1, 3'b001, '0, '0, 32'h0, 1'b0);
    n   = 0;
    fin = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      @(negedge clk);
      if (stall) begin
        n++;
        @(posedge clk);
        #1;
      end else begin
        fin = 1'b1;
      end
    end
    chk("div_stall_cycles", n, 32);
    chk("div_lo", result, 32'd14);
    @(posedge clk);
    #1 drv(1'b1, 3'b010, '0, '0, 32'h0, 1'b0);
    @(negedge clk);
    chk("div_hi", result, 32'd2);

    // flush on the 10th busy cycle, ALU pass while busy
    @(posedge clk);
    #1 drv(1'b1, 3'b000, 32'hFFFFFFFF, 32'd3, 32'h0, 1'b0);
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk);
      #1;
      if (j < 10) drv(1'b1, 3'b011, '0, '0, 32'hDEADBEEF, 1'b0);
      else        drv(1'b0, 3'b011, '0, '0, 32'h0, 1'b1);
      @(negedge clk);
      if (j == 5) begin
        chk("alu_busy_result", result, 32'hDEADBEEF);
        chk("alu_busy_stall", stall, 1'b0);
        chk("alu_busy_busy", busy, 1'b1);
      end
      if (j == 10) chk("flush_cycle_busy", busy, 1'b1);
    end
    @(posedge clk);
    #1 drv(1'b1, 3'b010, '0, '0, 32'h0, 1'b0);
    @(negedge clk);
    chk("flush_busy_after", busy, 1'b0);
    chk("flush_hi_kept", result, 32'd2);
    @(posedge clk);
    #1 drv(1'b1, 3'b001, '0, '0, 32'h0, 1'b0);
    @(negedge clk);
    chk("flush_lo_kept", result, 32'd14);
    @(posedge clk);
    #1 drv(1'b1, 3'b000, 32'd53, 32'd5, 32'h0, 1'b0);
    @(negedge clk);
    chk("restart_idle", busy, 1'b0);
    @(posedge clk);
    #1 drv(1'b0, 3'b011, '0, '0, 32'h0, 1'b0);
    wait_idle(n);
    chk("restart_busy_cycles", n, 32);
    @(posedge clk);
    #1 drv(1'b1, 3'b001, '0, '0, 32'h0, 1'b0);
    @(negedge clk);
    chk("restart_lo", result, 32'd10);
    @(posedge clk);
    #1 drv(1'b1, 3'b010, '0, '0, 32'h0, 1'b0);
    @(negedge clk);
    chk("restart_hi", result, 32'd3);

    // MULTU 0xFFFFFFFF * 2
    @(posedge clk);
    #1 drv(1'b1, 3'b100, 32'hFFFFFFFF, 32'd2, 32'h00000099, 1'b0);
    @(negedge clk);
    chk("mul_issue_result", result, 32'h00000099);
    chk("mul_issue_busy", busy, 1'b0);
    @(posedge clk);
    #1 drv(1'b0, 3'b011, '0, '0, 32'h0, 1'b0);
    wait_idle(n);
    chk("mul_busy_cycles", n, mul_cycles);
    @(posedge clk);
    #1 drv(1'b1, 3'b010, '0, '0, 32'h0, 1'b0);
    @(negedge clk);
    chk("mul_hi", result, mul_hi);
    @(posedge clk);
    #1 drv(1'b1, 3'b001, '0, '0, 32'h0, 1'b0);
    @(negedge clk);
    chk("mul_lo", result, mul_lo);

    // asynchronous reset in the middle of a division
    @(posedge clk);
    #1 drv(1'b1, 3'b000, 32'd1000, 32'd3, 32'h0, 1'b0);
    @(posedge clk);
    #1 drv(1'b1, 3'b010, '0, '0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_stall", stall, 1'b0);
    chk("rst_mid_hi", result, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drv(1'b1, 3'b001, '0, '0, 32'h0, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_lo_later", result, 32'h0);
    chk("rst_mid_busy_later", busy, 1'b0);

    // random traffic against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < 2500; i++) begin
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1, 2, 3: rb = W'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      drv($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, rb,
          $urandom, $urandom_range(0, 31) == 0);
      @(negedge clk);
      model_check();
      model_step();
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
